// File: rtl/stream_pattern_gen.sv
// stream_pattern_gen
// Burst generator that emits a counter or Galois-LFSR word sequence over a
// valid/ready stream, with an optional idle gap after every accepted word.
//
// Handshake: a word moves only in a cycle where valid_o=1 and ready_i=1.
// Once valid_o is raised it stays high, with data_o unchanged, until that
// transfer happens. The sink may hold ready_i high or low at any time.
//
// Ports
//   clk_i       clock, all state changes on the rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     burst request, looked at only while idle
//   mode_i      0 = counter pattern, 1 = LFSR pattern
//   len_i       words in the burst (0 = empty burst, only a done pulse)
//   gap_i       idle cycles inserted after each accepted word (not after the last)
//   seed_i      first word of the burst
//   ready_i     sink ready
//   valid_o     data_o holds a word on offer
//   data_o      stream word
//   busy_o      a burst is in progress (SEND, GAP or DONE)
//   done_o      one-cycle pulse at the end of a burst
//   sent_cnt_o  words accepted in the current or last burst
module stream_pattern_gen #(
  parameter int              WIDTH = 8,
  parameter int              LEN_W = 8,
  parameter int              GAP_W = 4,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] sent_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] sent_cnt_q, sent_cnt_d;
  // Burst configuration captured at start so input changes mid-burst are ignored.
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic             xfer;
  logic [WIDTH-1:0] next_word;
  logic [LEN_W-1:0] sent_inc;

  assign xfer     = valid_q & ready_i;
  assign sent_inc = sent_cnt_q + LEN_W'(1);

  always_comb begin
    next_word = '0;
    if (mode_q) begin
      next_word = (data_q >> 1) ^ (data_q[0] ? TAPS : '0);
    end else begin
      next_word = data_q + WIDTH'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    sent_cnt_d = sent_cnt_q;
    mode_d     = mode_q;
    len_d      = len_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d     = mode_i;
          len_d      = len_i;
          gap_d      = gap_i;
          sent_cnt_d = '0;
          // An all-zero LFSR would lock up, so a zero seed becomes 1.
          if (mode_i && (seed_i == '0)) begin
            data_d = WIDTH'(1);
          end else begin
            data_d = seed_i;
          end
          state_d = (len_i == '0) ? S_DONE : S_SEND;
        end
      end

      S_SEND: begin
        if (xfer) begin
          sent_cnt_d = sent_inc;
          data_d     = next_word;
          // sent_cnt never passes len-1 before this compare, so an all-ones
          // length reaches its last word without wrapping the counter.
          if (sent_inc == len_q) begin
            state_d = S_DONE;
          end else if (gap_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
          end
        end
      end

      S_GAP: begin
        // gap_cnt holds the number of GAP cycles still to spend, this one included.
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = S_SEND;
        end
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sent_cnt_q <= '0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sent_cnt_q <= sent_cnt_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sent_cnt_o = sent_cnt_q;

endmodule

// File: doc/stream_pattern_gen.md
STREAM_PATTERN_GEN -- requirements
Module: stream_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (>=2).
REQ-002 SHALL have parameter LEN_W, default 8, meaning width of the burst-length and sent-count fields.
REQ-003 SHALL have parameter GAP_W, default 4, meaning width of the inter-word gap field.
REQ-004 SHALL have parameter TAPS, default 8'hB8, WIDTH bits, meaning the Galois LFSR feedback mask.
REQ-005 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-007 SHALL have port start_i, input, 1, meaning a burst request, sampled only in IDLE.
REQ-008 SHALL have port mode_i, input, 1, meaning the pattern select: 0 for counter, 1 for LFSR.
REQ-009 SHALL have port len_i, input, LEN_W, meaning the number of words in the burst.
REQ-010 SHALL have port gap_i, input, GAP_W, meaning the number of idle cycles after each accepted word.
REQ-011 SHALL have port seed_i, input, WIDTH, meaning the first data word.
REQ-012 SHALL have port ready_i, input, 1, meaning sink backpressure.
REQ-013 SHALL have port valid_o, output, 1, meaning data_o holds a word on offer.
REQ-014 SHALL have port data_o, output, WIDTH, meaning the stream word.
REQ-015 SHALL have port busy_o, output, 1, meaning the FSM is not in IDLE.
REQ-016 SHALL have port done_o, output, 1, meaning a one-cycle pulse at burst end.
REQ-017 SHALL have port sent_cnt_o, output, LEN_W, meaning the words accepted in the current or last burst.

Function
REQ-018 SHALL implement FSM states IDLE, SEND, GAP and DONE, with all outputs driven from registers.
REQ-019 A transfer SHALL occur in any cycle with valid_o=1 and ready_i=1; no other condition SHALL count as a transfer.
REQ-020 In IDLE with start_i=1, the block SHALL latch mode_i, len_i, gap_i and seed_i and clear sent_cnt_o to 0.
REQ-021 On that same IDLE start edge, the FSM SHALL go to SEND, or to DONE if len_i==0.
REQ-022 In IDLE with start_i=1 and mode=1 and seed_i==0, the block SHALL load data_o with 1 (the LFSR never holds 0).
REQ-023 In SEND, valid_o SHALL be 1 (first valid cycle is the cycle after start is accepted); while ready_i=0, valid_o and data_o SHALL hold unchanged.
REQ-024 On each transfer, sent_cnt_o SHALL increment by 1.
REQ-025 On the transfer that is the len-th word, the FSM SHALL go to DONE and valid_o SHALL drop to 0 next cycle.
REQ-026 On any other transfer with latched gap>0, the FSM SHALL go to GAP with valid_o=0, stay there exactly gap cycles, then return to SEND.
REQ-027 On any other transfer with latched gap==0, the FSM SHALL stay in SEND and present the next word in the following cycle, giving back-to-back transfers.
REQ-028 Next-word rule in counter mode: the next word SHALL be data_o+1 modulo 2^WIDTH, wrapping all-ones to 0.
REQ-029 Next-word rule in LFSR mode: the next word SHALL be (data_o>>1) XOR (data_o[0] ? TAPS : 0).
REQ-030 The next word SHALL be computed at the transfer edge and held through GAP.
REQ-031 In DONE, done_o SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE; done_o SHALL be 0 in every other state.
REQ-032 busy_o SHALL be 1 in SEND, GAP and DONE, and 0 in IDLE.
REQ-033 start_i SHALL be ignored outside IDLE, and changes to mode_i, len_i, gap_i or seed_i SHALL have no effect mid-burst.
REQ-034 sent_cnt_o SHALL retain its final value in IDLE until the next accepted start.
REQ-035 When len_i is all-ones, the block SHALL send 2^LEN_W-1 words with no counter overflow.

Reset
REQ-036 While rst_ni=0, the block SHALL immediately (asynchronously) force state=IDLE, valid_o=0, data_o=0, busy_o=0, done_o=0 and sent_cnt_o=0.
REQ-037 A reset asserted mid-burst SHALL abandon the burst with no further transfers, and the first start after release SHALL begin a fresh burst.
REQ-038 Reset deassertion SHALL take effect at the next rising clk_i edge, and start_i SHALL be accepted from that edge.

Verification
REQ-039 Counter burst: mode=0, len=4, gap=0, seed=0x10, ready_i=1 -> data 0x10,0x11,0x12,0x13 on 4 consecutive cycles, done_o pulses in the next cycle, and sent_cnt_o=4.
REQ-040 Backpressure: same as REQ-039 but ready_i=0 for 3 cycles on the first word -> valid_o=1 with data 0x10 stable for 3 cycles, then the sequence resumes unchanged.
REQ-041 LFSR burst: mode=1, len=4, seed=0x01, TAPS=0xB8 -> data 0x01,0xB8,0x5C,0x2E; a second run with seed=0x00 -> the first word is 0x01.
REQ-042 Gap and wrap: mode=0, len=3, gap=2, seed=0xFF -> data 0xFF, then 2 cycles of valid_o=0, then 0x00, then 2 cycles of valid_o=0, then 0x01.
REQ-043 Corner cases: len=0 -> no valid_o and done_o one cycle after start; start_i pulsed mid-burst -> ignored.
REQ-044 Reset mid-burst: rst_ni=0 after 2 of 5 words -> valid_o=0 in the same cycle and sent_cnt_o=0, and the next start sends from seed.
